// File: rtl/cpu_control_unit_if.sv
// Bus bundle between the control unit and its instruction memory, register file and output consumer.
// The master side is the control unit; the slave side is the surrounding datapath/environment.
interface cpu_control_unit_if;
    logic [15:0] pc;
    logic [15:0] instruction;
    logic [2:0]  rf_raddr_a;
    logic [15:0] rf_rdata_a;
    logic [2:0]  rf_raddr_b;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halted;

    modport master (
        output pc, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               out_data, out_valid, halted,
        input  instruction, rf_rdata_a, rf_rdata_b, out_ready
    );

    modport slave (
        input  pc, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
               out_data, out_valid, halted,
        output instruction, rf_rdata_a, rf_rdata_b, out_ready
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core; 3-4 cycles per instruction, out stalls on ready.
// Optional CTRL_SINGLE_STEP_EN adds a 'step' port that gates FETCH.
module cpu_control_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic clk,
    input  logic rst,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic step,
`endif
    cpu_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_SWAP2  = 3'd3,
        S_OUT    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_JUMP = 3'b110;
    localparam logic [2:0] OP_REPL = 3'b111;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [15:0] r_ir;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_out_data;

    state_t      w_state_next;
    logic [15:0] w_pc_next;
    logic        w_ir_load;
    logic        w_out_load;
    logic        w_we;
    logic [2:0]  w_waddr;
    logic [15:0] w_wdata;
    logic        w_fetch_go;

    wire  [2:0]  w_op       = r_ir[15:13];
    wire  [2:0]  w_rd       = r_ir[12:10];
    wire  [2:0]  w_rs       = r_ir[9:7];
    wire  [15:0] w_imm_zext = {6'd0, r_ir[9:0]};
    wire  [15:0] w_imm_sext = {{6{r_ir[9]}}, r_ir[9:0]};
    wire  [15:0] w_pc_inc   = r_pc + 16'd1;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_fetch_go = step;
`else
    assign w_fetch_go = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_ir       <= 16'd0;
            r_a        <= 16'd0;
            r_b        <= 16'd0;
            r_out_data <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            if (w_ir_load)
                r_ir <= bus.instruction;
            if (r_state == S_DECODE) begin
                r_a <= bus.rf_rdata_a;
                r_b <= bus.rf_rdata_b;
            end
            if (w_out_load)
                r_out_data <= r_a;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_ir_load    = 1'b0;
        w_out_load   = 1'b0;
        w_we         = 1'b0;
        w_waddr      = 3'd0;
        w_wdata      = 16'd0;
        case (r_state)
            S_FETCH: begin
                if (w_fetch_go) begin
                    w_ir_load    = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC: begin
                w_pc_next    = w_pc_inc;
                w_state_next = S_FETCH;
                case (w_op)
                    OP_NOP: ;
                    OP_SUB: begin
                        w_we    = 1'b1;
                        w_waddr = w_rd;
                        w_wdata = r_a - r_b;
                    end
                    OP_ADD: begin
                        w_we    = 1'b1;
                        w_waddr = w_rd;
                        w_wdata = r_a + r_b;
                    end
                    OP_HALT: begin
                        w_pc_next    = r_pc;
                        w_state_next = S_HALT;
                    end
                    OP_OUT: begin
                        w_pc_next    = r_pc;
                        w_out_load   = 1'b1;
                        w_state_next = S_OUT;
                    end
                    OP_LDI: begin
                        w_we    = 1'b1;
                        w_waddr = w_rd;
                        w_wdata = w_imm_zext;
                    end
                    OP_JUMP: begin
                        if (r_a == 16'd0)
                            w_pc_next = r_pc + w_imm_sext;
                    end
                    OP_REPL: begin
                        // First half of the swap; A still holds the old rd for SWAP2.
                        w_pc_next    = r_pc;
                        w_we         = 1'b1;
                        w_waddr      = w_rd;
                        w_wdata      = r_b;
                        w_state_next = S_SWAP2;
                    end
                endcase
            end
            S_SWAP2: begin
                w_we         = 1'b1;
                w_waddr      = w_rs;
                w_wdata      = r_a;
                w_pc_next    = w_pc_inc;
                w_state_next = S_FETCH;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    w_pc_next    = w_pc_inc;
                    w_state_next = S_FETCH;
                end
            end
            S_HALT: ;
            default: w_state_next = S_FETCH;
        endcase
    end

    assign bus.pc         = r_pc;
    assign bus.rf_raddr_a = w_rd;
    assign bus.rf_raddr_b = w_rs;
    // Reset blocks the write at the same edge so an interrupted swap never completes.
    assign bus.rf_we      = w_we & ~rst;
    assign bus.rf_waddr   = w_waddr;
    assign bus.rf_wdata   = w_wdata;
    assign bus.out_data   = r_out_data;
    assign bus.out_valid  = (r_state == S_OUT);
    assign bus.halted     = (r_state == S_HALT);
endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: ISA-level reference model feeds expected outputs/writes into queues,
// a negedge monitor pops and compares on every out handshake and register write.
module tb_cpu_control_unit;
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_HALT = 3'b011;
    localparam logic [2:0] OP_OUT  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_JUMP = 3'b110;
    localparam logic [2:0] OP_REPL = 3'b111;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_regs = 1'b0;
    always #5 clk = ~clk;

    cpu_control_unit_if bus();

    cpu_control_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] imem [0:255];
    logic [15:0] regs [0:7];
    logic [15:0] prog [$];
    logic [15:0] exp_out [$];
    logic [18:0] exp_wr [$];
    int n_checks = 0;
    int n_errors = 0;
    int n_xfer   = 0;
    bit chk_wr   = 1'b0;

    assign bus.instruction = imem[bus.pc[7:0]];
    assign bus.rf_rdata_a  = regs[bus.rf_raddr_a];
    assign bus.rf_rdata_b  = regs[bus.rf_raddr_b];

    always @(posedge clk) begin
        if (clr_regs) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'd0;
        end else if (bus.rf_we) begin
            regs[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                if (exp_out.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_extra: got 0x%0h, expected no transfer", bus.out_data);
                end else begin
                    check("out_data", 32'(bus.out_data), 32'(exp_out.pop_front()));
                end
            end
            if (bus.rf_we && chk_wr) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL wr_extra: got r%0d<=0x%0h, expected no write", bus.rf_waddr, bus.rf_wdata);
                end else begin
                    check("rf_write", 32'({bus.rf_waddr, bus.rf_wdata}), 32'(exp_wr.pop_front()));
                end
            end
        end
    end

    function automatic logic [15:0] i_rr(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs, 7'd0};
    endfunction

    function automatic logic [15:0] i_im(input logic [2:0] op, input logic [2:0] rd, input logic [9:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic load_prog();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        for (int i = 0; i < prog.size(); i++) imem[i] = prog[i];
    endtask

    // Instruction-level interpreter: architectural effects and cycle cost per instruction.
    task automatic model_run(output logic [15:0] fpc, output int cyc);
        logic [15:0] r [0:7];
        logic [15:0] pc, ir, a, b, res;
        logic [2:0]  rd, rs;
        bit done;
        int steps;
        for (int i = 0; i < 8; i++) r[i] = 16'd0;
        pc = 16'd0; cyc = 0; done = 1'b0; steps = 0;
        while (!done && steps < 4000) begin
            ir = imem[pc[7:0]];
            rd = ir[12:10]; rs = ir[9:7];
            a = r[rd]; b = r[rs];
            steps++;
            case (ir[15:13])
                OP_NOP:  begin pc = pc + 16'd1; cyc += 3; end
                OP_SUB:  begin res = a - b; r[rd] = res; exp_wr.push_back({rd, res}); pc = pc + 16'd1; cyc += 3; end
                OP_ADD:  begin res = a + b; r[rd] = res; exp_wr.push_back({rd, res}); pc = pc + 16'd1; cyc += 3; end
                OP_HALT: begin cyc += 3; done = 1'b1; end
                OP_OUT:  begin exp_out.push_back(a); pc = pc + 16'd1; cyc += 4; end
                OP_LDI:  begin res = {6'd0, ir[9:0]}; r[rd] = res; exp_wr.push_back({rd, res}); pc = pc + 16'd1; cyc += 3; end
                OP_JUMP: begin
                    pc = (a == 16'd0) ? pc + {{6{ir[9]}}, ir[9:0]} : pc + 16'd1;
                    cyc += 3;
                end
                default: begin
                    r[rd] = b; exp_wr.push_back({rd, b});
                    r[rs] = a; exp_wr.push_back({rs, a});
                    pc = pc + 16'd1; cyc += 4;
                end
            endcase
        end
        fpc = pc;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        clr_regs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clr_regs = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget, output int n);
        n = 0;
        while (!bus.halted && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_halted"}, 32'(bus.halted), 1);
    endtask

    // dir_pc < 0 means only the model's final pc is used.
    task automatic run_prog(input string tag, input bit rnd_ready, input bit chk_cyc, input int dir_pc);
        logic [15:0] fpc;
        int cyc, n;
        exp_out.delete();
        exp_wr.delete();
        chk_wr = 1'b1;
        model_run(fpc, cyc);
        bus.out_ready = 1'b1;
        reset_dut();
        n = 0;
        while (!bus.halted && n < 20000) begin
            bus.out_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1; n++;
        end
        check({tag, "_halted"}, 32'(bus.halted), 1);
        check({tag, "_pc"}, 32'(bus.pc), 32'(fpc));
        if (dir_pc >= 0) check({tag, "_pc_dir"}, 32'(bus.pc), 32'(dir_pc));
        check({tag, "_out_left"}, 32'(exp_out.size()), 0);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 0);
        if (chk_cyc) check({tag, "_cycles"}, 32'(n), 32'(cyc));
        chk_wr = 1'b0;
    endtask

    task automatic gen_random();
        int n, k, j;
        logic [2:0] rd, rs;
        n = $urandom_range(6, 24);
        prog.delete();
        for (int i = 0; i < n; i++) begin
            k  = $urandom_range(0, 6);
            rd = 3'($urandom_range(0, 7));
            rs = 3'($urandom_range(0, 7));
            case (k)
                0: prog.push_back(i_rr(OP_NOP, rd, rs));
                1: prog.push_back(i_rr(OP_SUB, rd, rs));
                2: prog.push_back(i_rr(OP_ADD, rd, rs));
                3: prog.push_back(i_im(OP_LDI, rd, 10'($urandom_range(0, 1023))));
                4: prog.push_back(i_rr(OP_OUT, rd, rs));
                5: prog.push_back(i_rr(OP_REPL, rd, rs));
                default: begin
                    j = $urandom_range(1, 3);
                    if (i + j <= n) prog.push_back(i_im(OP_JUMP, rd, 10'(j)));
                    else prog.push_back(i_rr(OP_NOP, rd, rs));
                end
            endcase
        end
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, x0;
        bus.out_ready = 1'b0;
        prog.delete();
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        reset_dut();
        check("rst_pc",        32'(bus.pc), 0);
        check("rst_rf_we",     32'(bus.rf_we), 0);
        check("rst_rf_waddr",  32'(bus.rf_waddr), 0);
        check("rst_rf_wdata",  32'(bus.rf_wdata), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data",  32'(bus.out_data), 0);
        check("rst_halted",    32'(bus.halted), 0);

        // Countdown 10..0
        prog.delete();
        prog.push_back(i_im(OP_LDI, 3'd1, 10'd10));
        prog.push_back(i_im(OP_LDI, 3'd2, 10'd1));
        prog.push_back(i_im(OP_LDI, 3'd0, 10'd0));
        prog.push_back(i_rr(OP_OUT, 3'd1, 3'd0));
        prog.push_back(i_rr(OP_SUB, 3'd1, 3'd2));
        prog.push_back(i_im(OP_JUMP, 3'd1, 10'd2));
        prog.push_back(i_im(OP_JUMP, 3'd0, 10'h3FD));
        prog.push_back(i_rr(OP_OUT, 3'd1, 3'd0));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        x0 = n_xfer;
        run_prog("countdown", 1'b0, 1'b1, 16'h0008);
        check("countdown_nout", 32'(n_xfer - x0), 11);

        // Swap program: outputs 10 then 18
        prog.delete();
        prog.push_back(i_im(OP_LDI, 3'd0, 10'd28));
        prog.push_back(i_im(OP_LDI, 3'd1, 10'd10));
        prog.push_back(i_rr(OP_SUB, 3'd0, 3'd1));
        prog.push_back(i_rr(OP_REPL, 3'd0, 3'd1));
        prog.push_back(i_rr(OP_OUT, 3'd0, 3'd0));
        prog.push_back(i_rr(OP_OUT, 3'd1, 3'd0));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        run_prog("swap", 1'b0, 1'b1, 16'h0006);
        check("swap_r0", 32'(regs[0]), 10);
        check("swap_r1", 32'(regs[1]), 18);

        // Jump not taken at 0x0007
        prog.delete();
        prog.push_back(i_im(OP_LDI, 3'd2, 10'd5));
        for (int i = 0; i < 6; i++) prog.push_back(i_rr(OP_NOP, 3'd0, 3'd0));
        prog.push_back(i_im(OP_JUMP, 3'd2, 10'd4));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        run_prog("jmp_nt", 1'b0, 1'b1, 16'h0008);

        // Jump taken #2 at 0x000B
        prog.delete();
        for (int i = 0; i < 11; i++) prog.push_back(i_rr(OP_NOP, 3'd0, 3'd0));
        prog.push_back(i_im(OP_JUMP, 3'd0, 10'd2));
        prog.push_back(i_rr(OP_OUT, 3'd0, 3'd0));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        run_prog("jmp_t", 1'b0, 1'b1, 16'h000D);

        // Backward jump wraps below zero
        prog.delete();
        prog.push_back(i_rr(OP_NOP, 3'd0, 3'd0));
        prog.push_back(i_im(OP_JUMP, 3'd0, 10'h3FD));
        load_prog();
        imem[8'hFE] = i_rr(OP_HALT, 3'd0, 3'd0);
        run_prog("jmp_wrap", 1'b0, 1'b1, 16'hFFFE);

        // Max immediate, single write
        prog.delete();
        prog.push_back(i_im(OP_LDI, 3'd3, 10'h3FF));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        run_prog("ldi_max", 1'b0, 1'b1, 16'h0001);

        // Output stall: ready low while valid
        prog.delete();
        prog.push_back(i_im(OP_LDI, 3'd1, 10'd7));
        prog.push_back(i_rr(OP_OUT, 3'd1, 3'd0));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        exp_out.delete();
        bus.out_ready = 1'b0;
        reset_dut();
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("stall_valid_seen", 32'(bus.out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(bus.out_valid), 1);
            check("stall_data",  32'(bus.out_data), 7);
            check("stall_pc",    32'(bus.pc), 1);
        end
        exp_out.push_back(16'd7);
        x0 = n_xfer;
        bus.out_ready = 1'b1;
        wait_halt("stall", 100, n);
        check("stall_nxfer", 32'(n_xfer - x0), 1);
        check("stall_out_left", 32'(exp_out.size()), 0);
        check("stall_pc_end", 32'(bus.pc), 2);

        // Reset while in OUT
        exp_out.delete();
        bus.out_ready = 1'b0;
        reset_dut();
        n = 0;
        while (!bus.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        check("rout_valid_seen", 32'(bus.out_valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rout_valid", 32'(bus.out_valid), 0);
        check("rout_we", 32'(bus.rf_we), 0);
        check("rout_pc", 32'(bus.pc), 0);
        rst = 1'b0;
        exp_out.push_back(16'd7);
        bus.out_ready = 1'b1;
        wait_halt("rout", 100, n);
        check("rout_out_left", 32'(exp_out.size()), 0);
        check("rout_pc_end", 32'(bus.pc), 2);

        // Reset while in SWAP2
        prog.delete();
        prog.push_back(i_im(OP_LDI, 3'd0, 10'd5));
        prog.push_back(i_im(OP_LDI, 3'd1, 10'd9));
        prog.push_back(i_rr(OP_REPL, 3'd0, 3'd1));
        prog.push_back(i_rr(OP_HALT, 3'd0, 3'd0));
        load_prog();
        reset_dut();
        n = 0;
        while (!(bus.rf_we && bus.rf_waddr == 3'd0 && bus.rf_wdata == 16'd9) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("rswap_exec_seen", 32'(bus.rf_wdata), 9);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rswap_we", 32'(bus.rf_we), 0);
        check("rswap_pc", 32'(bus.pc), 0);
        check("rswap_r1_kept", 32'(regs[1]), 9);
        rst = 1'b0;
        wait_halt("rswap", 100, n);
        check("rswap_pc_end", 32'(bus.pc), 3);
        check("rswap_r0", 32'(regs[0]), 9);
        check("rswap_r1", 32'(regs[1]), 5);

        // Random programs, half with random backpressure
        for (int t = 0; t < 30; t++) begin
            gen_random();
            load_prog();
            run_prog("rand", t[0], !t[0], -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
